monopix_readout_tx: RTL

//  Chip-side end of the MONOPIX token/freeze/read serial readout protocol.
//  - Buffers hit words arriving from the pixel/EoC logic.
//  - Raises token while hits are pending.
//  - On read from the readout controller, serialises one 27-bit word MSB-first on data_out.
//  - Bit timing matches the controller's 4-stage read-edge pipeline (clk_out tied to clk_bx).

---
 rtl/monopix_ro_pkg.sv | 20 ++
 rtl/monopix_hit_fifo.sv | 68 ++++++
 rtl/monopix_readout_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/monopix_ro_pkg.sv
// Shared types and helpers for the MONOPIX chip-side readout transmitter.
// t_data is the 27-bit serial word. Its fields, from MSB to LSB, are:
//   col (6) | row (9) | gray(le) (6) | gray(te) (6)
package monopix_ro_pkg;

  localparam int DATA_W = 27;

  typedef struct packed {
    logic [5:0] col;
    logic [8:0] row;
    logic [5:0] le;
    logic [5:0] te;
  } t_data;

  // Binary to reflected-Gray conversion for 6-bit timestamps.
  function automatic logic [5:0] bin2gray6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/monopix_hit_fifo.sv
// Synchronous hit FIFO of t_data words, DEPTH entries (power of 2).
// Ports:
//   clk_bx, reset    : clock, synchronous active-high reset
//   push_i, wdata_i  : push request and data. It is accepted if the FIFO is not
//                      full, or if a pop happens on the same edge.
//   pop_i            : pop request. It is ignored when the FIFO is empty.
//   head_o           : oldest word. It is valid while !empty_o.
//   full_o, empty_o  : status
//   count_o          : current occupancy
//   count_next_o     : occupancy after this edge's push/pop
//   drop_o           : a push request was refused on this edge
module monopix_hit_fifo
  import monopix_ro_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_bx,
  input  logic                     reset,
  input  logic                     push_i,
  input  t_data                    wdata_i,
  input  logic                     pop_i,
  output t_data                    head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  t_data           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    empty_o      = (count_q == '0);
    full_o       = (count_q == CW'(DEPTH));
    do_pop       = pop_i && !empty_o;
    // When the FIFO is full, the push is accepted only if a pop frees an entry on the same edge.
    do_push      = push_i && (!full_o || do_pop);
    drop_o       = push_i && !do_push;
    count_next_o = count_q + CW'(do_push) - CW'(do_pop);
    head_o       = mem_q[rd_ptr_q];
    count_o      = count_q;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_next_o;
    end
  end

endmodule

// File: rtl/monopix_readout_tx.sv
// Chip-side end of the MONOPIX token/freeze/read serial readout.
// The block buffers hit words and raises token while hits are pending.
// On each read rise it serialises one 27-bit word, MSB first, on data_out.
// Ports:
//   clk_bx, reset           : clock, synchronous active-high reset
//   hit_valid/hit_ready     : hit input handshake (see below)
//   hit_col/row/le/te       : hit fields. le and te are binary and are Gray-coded at push.
//   freeze, read            : controller strobes. Only their rising edges matter.
//   token                   : registered "hits pending"
//   data_out, busy          : serial data and shift-in-progress flag
//   fifo_count              : FIFO occupancy
//   overflow_cnt            : saturating count of dropped hits
//   proto_err               : sticky flag for a read while busy or a read with nothing to send
//
// Handshake: a hit is transferred on a posedge where hit_valid && hit_ready.
// hit_ready is simply !full and does not depend on hit_valid.
// A hit offered while hit_ready is low is still accepted if a read pops the FIFO on that same edge.
// Otherwise the hit is dropped and counted in overflow_cnt.
//
// Serial timing for a read rise sampled at posedge N:
//   N       : load the shift register, pop the FIFO, set busy, set the start delay to 2
//   N+1,N+2 : the start delay counts down
//   N+3+k   : data_out = word[26-k], for k = 0..26 (bit_cnt goes 0 -> 27)
//   N+30    : data_out = 0, busy = 0
module monopix_readout_tx
  import monopix_ro_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVF_W = 8
) (
  input  logic                   clk_bx,
  input  logic                   reset,
  input  logic                   hit_valid,
  input  logic [5:0]             hit_col,
  input  logic [8:0]             hit_row,
  input  logic [5:0]             hit_le,
  input  logic [5:0]             hit_te,
  output logic                   hit_ready,
  input  logic                   freeze,
  input  logic                   read,
  output logic                   token,
  output logic                   data_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   proto_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  t_data              hit_word;
  t_data              head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;
  logic               fifo_drop;
  logic               read_rise;
  logic               freeze_rise;
  logic               start;

  logic               freeze_q,   freeze_d;
  logic               read_q,     read_d;
  t_data              hold_q,     hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]  shift_q,    shift_d;
  logic               busy_q,     busy_d;
  logic [1:0]         dly_q,      dly_d;
  logic [4:0]         bit_cnt_q,  bit_cnt_d;
  logic               dout_q,     dout_d;
  logic               token_q,    token_d;
  logic [OVF_W-1:0]   ovf_q,      ovf_d;
  logic               perr_q,     perr_d;

  always_comb begin
    hit_word.col = hit_col;
    hit_word.row = hit_row;
    hit_word.le  = bin2gray6(hit_le);
    hit_word.te  = bin2gray6(hit_te);
    read_rise    = read && !read_q;
    freeze_rise  = freeze && !freeze_q;
    start        = read_rise && !busy_q;
  end

  // The FIFO ignores the pop request when it is empty.
  // That is the "read with nothing to send" case, which serialises zeros.
  monopix_hit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_bx       (clk_bx),
    .reset        (reset),
    .push_i       (hit_valid),
    .wdata_i      (hit_word),
    .pop_i        (start),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (count),
    .count_next_o (count_next),
    .drop_o       (fifo_drop)
  );

  always_comb begin
    freeze_d   = freeze;
    read_d     = read;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    dly_d      = dly_q;
    bit_cnt_d  = bit_cnt_q;
    dout_d     = dout_q;
    token_d    = (count_next != '0);
    ovf_d      = ovf_q;
    perr_d     = perr_q;

    if (freeze_rise && !fifo_empty) begin
      hold_d     = head;
      hold_vld_d = 1'b1;
    end

    if (busy_q) begin
      if (dly_q != 2'd0) begin
        dly_d = dly_q - 2'd1;
      end else if (bit_cnt_q == 5'd27) begin
        busy_d = 1'b0;
        dout_d = 1'b0;
      end else begin
        dout_d    = shift_q[DATA_W-1];
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (read_rise) begin
      if (busy_q) begin
        perr_d = 1'b1;
      end else begin
        // The hold register is a copy of the FIFO head, so the FIFO is popped in either case.
        // The read clears hold_vld_d and so wins over a freeze capture on the same edge.
        if (hold_vld_q)       shift_d = hold_q;
        else if (!fifo_empty) shift_d = head;
        else begin
          shift_d = '0;
          perr_d  = 1'b1;
        end
        hold_vld_d = 1'b0;
        busy_d     = 1'b1;
        dly_d      = 2'd2;
        bit_cnt_d  = 5'd0;
        dout_d     = 1'b0;
      end
    end

    if (fifo_drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      freeze_q   <= 1'b0;
      read_q     <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      dly_q      <= 2'd0;
      bit_cnt_q  <= 5'd0;
      dout_q     <= 1'b0;
      token_q    <= 1'b0;
      ovf_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      freeze_q   <= freeze_d;
      read_q     <= read_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      dly_q      <= dly_d;
      bit_cnt_q  <= bit_cnt_d;
      dout_q     <= dout_d;
      token_q    <= token_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    hit_ready    = !fifo_full;
    token        = token_q;
    data_out     = dout_q;
    busy         = busy_q;
    fifo_count   = count;
    overflow_cnt = ovf_q;
    proto_err    = perr_q;
  end

endmodule
